// File: rtl/scratchpad_copy_master.sv
// Avalon-MM master that copies a block of words inside the 16K x 32 scratchpad, 3 cycles per word.
// Optional running checksum of written words: define SCRATCHPAD_COPY_CHECKSUM_EN.
module scratchpad_copy_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_W-1:0]     src_addr_i,
  input  logic [ADDR_W-1:0]     dst_addr_i,
  input  logic [LEN_W-1:0]      length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [LEN_W-1:0]      words_done_o,
  output logic [ADDR_W-1:0]     avm_address_o,
  output logic                  avm_chipselect_o,
  output logic                  avm_write_o,
  output logic [DATA_W/8-1:0]   avm_byteenable_o,
  output logic [DATA_W-1:0]     avm_writedata_o,
  output logic                  avm_clken_o,
  input  logic [DATA_W-1:0]     avm_readdata_i
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_FIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aborted_q, aborted_d;
  logic                start_accept;

  assign start_accept = (state_q == S_IDLE) && start_i;
  assign cnt_inc      = cnt_q + LEN_W'(1);

  // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d     = src_addr_i;
          dst_d     = dst_addr_i;
          len_d     = length_i;
          cnt_d     = '0;
          aborted_d = 1'b0;
          if (length_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
            addr_d  = src_addr_i;
          end
        end
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: begin
        wdata_d = avm_readdata_i;
        addr_d  = dst_q + ADDR_W'(cnt_q);
        state_d = S_WR;
      end
      S_WR: begin
        cnt_d = cnt_inc;
        // Completion wins over abort: the last word never reports an abort.
        if (cnt_inc == len_q) begin
          state_d = S_FIN;
        end else if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          addr_d  = src_q + ADDR_W'(cnt_inc);
          state_d = S_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_accept)          sum_d = '0;
    else if (state_q == S_WR)  sum_d = sum_q + wdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign checksum_o = sum_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

  assign busy_o           = (state_q == S_RD) || (state_q == S_RWAIT) || (state_q == S_WR);
  assign done_o           = (state_q == S_FIN);
  assign aborted_o        = aborted_q;
  assign words_done_o     = cnt_q;
  assign avm_address_o    = addr_q;
  assign avm_chipselect_o = (state_q == S_RD) || (state_q == S_WR);
  assign avm_write_o      = (state_q == S_WR);
  assign avm_byteenable_o = '1;
  assign avm_writedata_o  = wdata_q;
  assign avm_clken_o      = 1'b1;

endmodule

// File: tb/tb_scratchpad_copy_master.sv
// Scoreboard bench for scratchpad_copy_master: a block-copy reference model predicts bus traffic and
// completion records; a negedge monitor pops and compares them against the DUT.
module tb_scratchpad_copy_master;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 15;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start_i = 1'b0, abort_i = 1'b0;
  logic [ADDR_W-1:0] src_i = '0, dst_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              busy_o, done_o, aborted_o, cs_o, we_o, clken_o;
  logic [LEN_W-1:0]  words_done_o;
  logic [ADDR_W-1:0] addr_o;
  logic [3:0]        be_o;
  logic [DATA_W-1:0] wdata_o;
  logic [DATA_W-1:0] rdata = '0;
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_o;
`endif

  scratchpad_copy_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .src_addr_i(src_i), .dst_addr_i(dst_i), .length_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .words_done_o(words_done_o),
    .avm_address_o(addr_o), .avm_chipselect_o(cs_o), .avm_write_o(we_o),
    .avm_byteenable_o(be_o), .avm_writedata_o(wdata_o), .avm_clken_o(clken_o),
    .avm_readdata_i(rdata)
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  // Scratchpad slave with fixed 1-cycle read latency.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  always @(posedge clk) begin
    if (cs_o && clken_o) begin
      if (we_o) mem[addr_o] = wdata_o;
      else      rdata <= mem[addr_o];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { int exp_cyc; int words; bit aborted; logic [DATA_W-1:0] sum; } done_t;
  logic [ADDR_W-1:0] rd_q[$];
  wr_t               wr_q[$];
  done_t             done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event with empty scoreboard required=none (t=%0t)", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a bus cycle or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (cs_o && !we_o) begin
        if (rd_q.size() == 0) unexpected("rd_cycle");
        else check("rd_addr", addr_o, rd_q.pop_front());
      end
      if (cs_o && we_o) begin
        if (wr_q.size() == 0) unexpected("wr_cycle");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", addr_o, w.a);
          check("wr_data", wdata_o, w.d);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) unexpected("done_pulse");
        else begin
          done_t e;
          e = done_q.pop_front();
          check("done_cycle", cyc, e.exp_cyc);
          check("words_done", words_done_o, e.words);
          check("aborted", aborted_o, e.aborted);
          check("busy_at_done", busy_o, 0);
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
          check("checksum", checksum_o, e.sum);
`endif
        end
      end
    end
  end

  // Reference model: ascending word-by-word copy with wrap; abort after word k when k < len.
  task automatic model_op(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                          input int n, output logic [DATA_W-1:0] sum);
    sum = '0;
    for (int j = 0; j < n; j++) begin
      logic [ADDR_W-1:0] s, d;
      wr_t w;
      s = ADDR_W'((int'(src) + j) % DEPTH);
      d = ADDR_W'((int'(dst) + j) % DEPTH);
      rd_q.push_back(s);
      w.a = d;
      w.d = ref_mem[s];
      wr_q.push_back(w);
      ref_mem[d] = ref_mem[s];
      sum += ref_mem[s];
    end
  endtask

  task automatic run_op(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                        input int len, input int abort_at, input bit poke);
    int n, kstart;
    bit ab, seen;
    logic [DATA_W-1:0] sum;
    done_t e;
    n  = len;
    ab = 1'b0;
    if (abort_at > 0 && abort_at < len) begin
      n  = abort_at;
      ab = 1'b1;
    end
    model_op(src, dst, n, sum);
    @(negedge clk);
    src_i = src; dst_i = dst; len_i = LEN_W'(len); start_i = 1'b1;
    @(posedge clk);
    #1;
    kstart  = cyc;
    start_i = 1'b0;
    e.exp_cyc = kstart + 3 * n;
    e.words   = n;
    e.aborted = ab;
    e.sum     = sum;
    done_q.push_back(e);
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (abort_at > 0 && cyc == kstart + 3 * (abort_at - 1)) abort_i = 1'b1;
      if (poke && t == 2) begin
        src_i = 14'h1234; dst_i = 14'h2345; len_i = 15'd5; start_i = 1'b1;
      end
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      rd_q.delete(); wr_q.delete(); done_q.delete();
    end
    @(negedge clk);
    check("aborted_hold", aborted_o, ab);
    check("words_done_hold", words_done_o, n);
  endtask

  initial begin
    logic [DATA_W-1:0] sum;
    done_t e;
    int mism;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #2 rst = 1'b1;
    #10;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_aborted", aborted_o, 0);
    check("rst_cs", cs_o, 0);
    check("rst_write", we_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_words_done", words_done_o, 0);
    check("rst_byteenable", be_o, 4'hF);
    check("rst_clken", clken_o, 1);
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
    check("rst_checksum", checksum_o, 0);
`endif
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_cs", cs_o, 0);
    end

    // Directed block copy.
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
    run_op(14'h0000, 14'h0100, 4, 0, 1'b0);
    check("copy_w0", mem[14'h100], 32'h11111111);
    check("copy_w1", mem[14'h101], 32'h22222222);
    check("copy_w2", mem[14'h102], 32'h33333333);
    check("copy_w3", mem[14'h103], 32'h44444444);

    run_op(14'h0050, 14'h0060, 0, 0, 1'b0);       // zero length
    run_op(14'h3FFE, 14'h0010, 4, 0, 1'b0);       // source wraps
    run_op(14'h0700, 14'h0800, 10, 2, 1'b1);      // abort on word 2, start while busy
    run_op(14'h0200, 14'h0202, 6, 0, 1'b0);       // overlapping ascending copy
    run_op(14'h0900, 14'h0A00, 3, 3, 1'b0);       // abort on last word has no effect

    mem[14'h20] = 32'h1; mem[14'h21] = 32'h2; mem[14'h22] = 32'hFFFFFFFF;
    for (int i = 14'h20; i < 14'h23; i++) ref_mem[i] = mem[i];
    run_op(14'h0020, 14'h0030, 3, 0, 1'b0);
`ifdef SCRATCHPAD_COPY_CHECKSUM_EN
    check("checksum_wrap", checksum_o, 32'h2);
`endif

    for (int r = 0; r < 15; r++) begin
      int len, ab_at;
      len   = $urandom_range(0, 12);
      ab_at = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
      run_op(ADDR_W'($urandom), ADDR_W'($urandom), len, ab_at, (len >= 2) && ($urandom_range(0, 1) == 1));
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image_mismatches", mism, 0);

    // Reset in the middle of a copy.
    model_op(14'h0400, 14'h0500, 8, sum);
    @(negedge clk);
    src_i = 14'h0400; dst_i = 14'h0500; len_i = 15'd8; start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_cs", cs_o, 0);
    check("midrst_write", we_o, 0);
    check("midrst_words_done", words_done_o, 0);
    rd_q.delete(); wr_q.delete(); done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_cs", cs_o, 0);
    end

    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
